inst_decode_queue: RTL and testbench

Parametrised decode buffer between instruction fetch and issue. Accepts up to W fetched instructions per cycle and decodes each lane on entry into an instruction sign (class) and ALU op. Decoded entries are held in a DEPTH-entry circular queue; issue drains up to W in-order entries per cycle. A one-cycle flush empties the queue on redirect.

---
 rtl/inst_decode_queue.sv | 125 ++++++++++++
 tb/tb_inst_decode_queue.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/inst_decode_queue.sv
// Decode buffer between fetch and issue: decodes up to W instructions per cycle on entry
// and holds them in a DEPTH-entry circular queue drained in order, up to W per cycle.
module inst_decode_queue #(
   parameter int W       = 2,
   parameter int DEPTH   = 16,
   parameter int ALUOP_W = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic [W-1:0]                 in_valid,
   input  logic [32*W-1:0]              in_pc,
   input  logic [32*W-1:0]              in_inst,
   output logic                         in_ready,
   output logic [W-1:0]                 out_valid,
   input  logic                         out_ready,
   output logic [32*W-1:0]              out_pc,
   output logic [32*W-1:0]              out_inst,
   output logic [3*W-1:0]               out_sign,
   output logic [ALUOP_W*W-1:0]         out_aluop,
   output logic [W-1:0]                 out_ine,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   push_amt, pop_amt;
   logic               do_push, do_pop;

   logic [31:0]        pc_mem    [DEPTH];
   logic [31:0]        inst_mem  [DEPTH];
   logic [2:0]         sign_mem  [DEPTH];
   logic [ALUOP_W-1:0] aluop_mem [DEPTH];
   logic               ine_mem   [DEPTH];

   logic [2:0]         dec_sign_p0  [W];
   logic [ALUOP_W-1:0] dec_aluop_p0 [W];
   logic               dec_ine_p0   [W];

   function automatic void decode(input logic [31:0] inst, output logic [2:0] sign,
                                  output logic [ALUOP_W-1:0] aluop, output logic ine);
      sign  = 3'd0;
      aluop = '0;
      ine   = 1'b0;
      if      (inst[31:15] == 17'h00020) begin sign = 3'd1; aluop = ALUOP_W'(1); end
      else if (inst[31:15] == 17'h00022) begin sign = 3'd1; aluop = ALUOP_W'(2); end
      else if (inst[31:15] == 17'h00029) begin sign = 3'd1; aluop = ALUOP_W'(3); end
      else if (inst[31:15] == 17'h0002a) begin sign = 3'd1; aluop = ALUOP_W'(4); end
      else if (inst[31:15] == 17'h0002b) begin sign = 3'd1; aluop = ALUOP_W'(5); end
      else if (inst[31:22] == 10'h00a)   begin sign = 3'd1; aluop = ALUOP_W'(1); end
      else if (inst[31:25] == 7'h0a)     begin sign = 3'd1; aluop = ALUOP_W'(6); end
      else if (inst[31:22] == 10'h0a2)   begin sign = 3'd2; aluop = ALUOP_W'(1); end
      else if (inst[31:22] == 10'h0a6)   begin sign = 3'd3; aluop = ALUOP_W'(1); end
      else if (inst[31:26] == 6'h16)     sign = 3'd4;
      else if (inst == 32'h06483800)     sign = 3'd5;
      else if (inst[31:15] == 17'h00056) sign = 3'd5;
      else                               ine  = 1'b1;
   endfunction

   function automatic logic [CNT_W-1:0] popcnt(input logic [W-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < W; i++) n = n + CNT_W'(v[i]);
      return n;
   endfunction

   always_comb begin
      for (int i = 0; i < W; i++)
         decode(in_inst[32*i +: 32], dec_sign_p0[i], dec_aluop_p0[i], dec_ine_p0[i]);
   end

   // in_ready looks only at the registered count so fetch never waits on issue timing
   assign in_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(W);
   assign do_push  = in_ready & in_valid[0] & ~flush;
   assign do_pop   = out_ready & out_valid[0] & ~flush;
   assign push_amt = do_push ? popcnt(in_valid) : '0;
   assign pop_amt  = !do_pop ? '0 : ((count >= CNT_W'(W)) ? CNT_W'(W) : count);

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(push_amt);
         rd_ptr <= rd_ptr + PTR_W'(pop_amt);
         count  <= count + push_amt - pop_amt;
      end
   end

   // ---- stage p0 -> storage: decoded lanes written at wr_ptr, wrapping modulo DEPTH
   always_ff @(posedge clk) begin
      for (int i = 0; i < W; i++) begin
         if (do_push && in_valid[i]) begin
            pc_mem[wr_ptr + PTR_W'(i)]    <= in_pc[32*i +: 32];
            inst_mem[wr_ptr + PTR_W'(i)]  <= in_inst[32*i +: 32];
            sign_mem[wr_ptr + PTR_W'(i)]  <= dec_sign_p0[i];
            aluop_mem[wr_ptr + PTR_W'(i)] <= dec_aluop_p0[i];
            ine_mem[wr_ptr + PTR_W'(i)]   <= dec_ine_p0[i];
         end
      end
   end

   always_comb begin
      out_valid = '0;
      out_pc    = '0;
      out_inst  = '0;
      out_sign  = '0;
      out_aluop = '0;
      out_ine   = '0;
      for (int i = 0; i < W; i++) begin
         if (count > CNT_W'(i)) begin
            out_valid[i]                  = 1'b1;
            out_pc[32*i +: 32]            = pc_mem[rd_ptr + PTR_W'(i)];
            out_inst[32*i +: 32]          = inst_mem[rd_ptr + PTR_W'(i)];
            out_sign[3*i +: 3]            = sign_mem[rd_ptr + PTR_W'(i)];
            out_aluop[ALUOP_W*i +: ALUOP_W] = aluop_mem[rd_ptr + PTR_W'(i)];
            out_ine[i]                    = ine_mem[rd_ptr + PTR_W'(i)];
         end
      end
   end

endmodule

// File: tb/tb_inst_decode_queue.sv
// Directed and randomized bench for inst_decode_queue against a queue-based reference model.
module tb_inst_decode_queue;

   localparam int W       = 2;
   localparam int DEPTH   = 16;
   localparam int ALUOP_W = 4;

   logic                       clk = 1'b0;
   logic                       rst_n, flush, out_ready, in_ready;
   logic [W-1:0]               in_valid, out_valid, out_ine;
   logic [32*W-1:0]            in_pc, in_inst, out_pc, out_inst;
   logic [3*W-1:0]             out_sign;
   logic [ALUOP_W*W-1:0]       out_aluop;
   logic [$clog2(DEPTH+1)-1:0] count;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] pc_ctr = 32'h1000;
   logic [31:0] pool [13] = '{32'h00100c41, 32'h00111234, 32'h00148421, 32'h00150c41,
                              32'h00158041, 32'h02800421, 32'h14000021, 32'h28800022,
                              32'h29800022, 32'h58000400, 32'h06483800, 32'h002b0000,
                              32'hffffffff};

   inst_decode_queue #(.W(W), .DEPTH(DEPTH), .ALUOP_W(ALUOP_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
      .in_inst(in_inst), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst), .out_sign(out_sign), .out_aluop(out_aluop),
      .out_ine(out_ine), .count(count)
   );

   always #5 clk = ~clk;

   // Reference decode expressed as shifted-opcode comparisons from the encoding table
   function automatic void ref_decode(input logic [31:0] x, output int s, output int op, output int ine);
      s = 0; op = 0; ine = 0;
      if      ((x >> 15) == 32'h20)  begin s = 1; op = 1; end
      else if ((x >> 15) == 32'h22)  begin s = 1; op = 2; end
      else if ((x >> 15) == 32'h29)  begin s = 1; op = 3; end
      else if ((x >> 15) == 32'h2a)  begin s = 1; op = 4; end
      else if ((x >> 15) == 32'h2b)  begin s = 1; op = 5; end
      else if ((x >> 22) == 32'h0a)  begin s = 1; op = 1; end
      else if ((x >> 25) == 32'h0a)  begin s = 1; op = 6; end
      else if ((x >> 22) == 32'ha2)  begin s = 2; op = 1; end
      else if ((x >> 22) == 32'ha6)  begin s = 3; op = 1; end
      else if ((x >> 26) == 32'h16)  s = 4;
      else if (x == 32'h06483800)    s = 5;
      else if ((x >> 15) == 32'h56)  s = 5;
      else                           ine = 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      int s, op, ine;
      int n;
      n = q.size();
      chk("count", 32'(count), 32'(n));
      chk("in_ready", 32'(in_ready), 32'((DEPTH - n) >= W));
      for (int i = 0; i < W; i++) begin
         if (i < n) ref_decode(q[i].inst, s, op, ine);
         else begin s = 0; op = 0; ine = 0; end
         chk($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(i < n));
         chk($sformatf("out_pc[%0d]", i), out_pc[32*i +: 32], (i < n) ? q[i].pc : 32'h0);
         chk($sformatf("out_inst[%0d]", i), out_inst[32*i +: 32], (i < n) ? q[i].inst : 32'h0);
         chk($sformatf("out_sign[%0d]", i), 32'(out_sign[3*i +: 3]), 32'(s));
         chk($sformatf("out_aluop[%0d]", i), 32'(out_aluop[ALUOP_W*i +: ALUOP_W]), 32'(op));
         chk($sformatf("out_ine[%0d]", i), 32'(out_ine[i]), 32'(ine));
      end
   endtask

   // Drive one cycle: check current outputs, advance the model, clock the DUT
   task automatic step(input logic r_n, input logic fl, input logic [W-1:0] v,
                       input logic [32*W-1:0] insts, input logic ordy);
      int   sz, npop;
      bit   rdy;
      ent_t e;
      logic [32*W-1:0] pcs;
      for (int i = 0; i < W; i++) pcs[32*i +: 32] = pc_ctr + 32'(4 * i);
      rst_n = r_n; flush = fl; in_valid = v; in_pc = pcs; in_inst = insts; out_ready = ordy;
      assert ((({1'b0, v} + 1) & {1'b0, v}) == 0) else $fatal(1, "FAIL protocol in_valid=%b", v);
      compare_all();
      if (!r_n || fl) q.delete();
      else begin
         sz   = q.size();
         rdy  = (DEPTH - sz) >= W;
         npop = (sz < W) ? sz : W;
         if (ordy) repeat (npop) void'(q.pop_front());
         if (rdy && v[0]) begin
            for (int i = 0; i < W; i++)
               if (v[i]) begin
                  e.pc = pcs[32*i +: 32];
                  e.inst = insts[32*i +: 32];
                  q.push_back(e);
               end
         end
      end
      pc_ctr = pc_ctr + 32'(4 * W);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [32*W-1:0] rand_insts();
      logic [32*W-1:0] r;
      for (int i = 0; i < W; i++)
         r[32*i +: 32] = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 12)];
      return r;
   endfunction

   initial begin
      logic [W-1:0] v;
      rst_n = 1'b0; flush = 1'b0; in_valid = '0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      step(1'b0, 1'b0, 2'b00, '0, 1'b0);
      // decode of the basic ALU pair and the mixed-class group
      step(1'b1, 1'b0, 2'b11, {32'h02800421, 32'h00100c41}, 1'b0);
      step(1'b1, 1'b0, 2'b11, {32'h28800022, 32'h14000021}, 1'b0);
      step(1'b1, 1'b0, 2'b11, {32'hffffffff, 32'h06483800}, 1'b0);
      step(1'b1, 1'b0, 2'b01, {32'h0, 32'h29800022}, 1'b1);
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 2'b00, '0, 1'b1);
      // fill to the full threshold, then push against it
      for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 2'b11, rand_insts(), 1'b0);
      step(1'b1, 1'b0, 2'b11, rand_insts(), 1'b1);
      step(1'b1, 1'b0, 2'b00, '0, 1'b0);
      // sustained throughput across pointer wrap
      for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 2'b11, rand_insts(), 1'b1);
      // flush with push and pop active
      step(1'b1, 1'b1, 2'b00, '0, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 2'b11, rand_insts(), 1'b0);
      step(1'b1, 1'b1, 2'b11, rand_insts(), 1'b1);
      step(1'b1, 1'b0, 2'b00, '0, 1'b0);
      // reset mid-stream at count 9
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 2'b11, rand_insts(), 1'b0);
      step(1'b1, 1'b0, 2'b01, rand_insts(), 1'b0);
      step(1'b0, 1'b0, 2'b11, rand_insts(), 1'b1);
      step(1'b1, 1'b0, 2'b11, {32'h002b0000, 32'h58000400}, 1'b0);
      step(1'b1, 1'b0, 2'b00, '0, 1'b0);
      // randomized traffic with occasional flush and reset
      for (int k = 0; k < 500; k++) begin
         case ($urandom_range(0, 2))
            0:       v = 2'b00;
            1:       v = 2'b01;
            default: v = 2'b11;
         endcase
         step(($urandom_range(0, 59) != 0), ($urandom_range(0, 24) == 0), v, rand_insts(),
              ($urandom_range(0, 2) != 0));
      end
      in_valid = '0; out_ready = 1'b0; flush = 1'b0; rst_n = 1'b1;
      compare_all();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
